// File: rtl/dcache1_tag_bank_pkg.sv
// dc1_tag_pkg: shared types and field layout for one way of the L1 D-cache
// tag array (dcache1_tag_bank).
//   - dc1_state_e      : init / run / flush sweep states
//   - dc1_tag_entry_t  : decoded status flags of one entry
//   - OFF_*            : bit offsets of the status fields above the tag
//   - dc1_ent_w()      : stored entry width for a given tag width
// Optional feature macro: DCACHE1_TAG_PARITY_EN (adds one stored parity bit).
package dc1_tag_pkg;

  typedef enum logic [1:0] {INIT, RUN, FLUSH} dc1_state_e;

  // Stored word is {parity, excl, recent, tag}; the tag sits at [TAG_W-1:0]
  // and these offsets are relative to TAG_W. Valid lives in its own array.
  localparam int OFF_RECENT = 0;
  localparam int OFF_EXCL   = 1;
  localparam int OFF_PARITY = 2;

  // The tag width is a module parameter, so the tag travels alongside this
  // struct rather than inside it.
  typedef struct packed {
    logic parity;
    logic excl;
    logic recent;
    logic valid;
  } dc1_tag_entry_t;

  function automatic int dc1_ent_w(input int tag_w);
`ifdef DCACHE1_TAG_PARITY_EN
    return tag_w + 3;
`else
    return tag_w + 2;
`endif
  endfunction

endpackage

// File: rtl/dcache1_tag_bank_if.sv
// dcache1_tag_bank_if: lookup / fill / snoop bus of one tag-array way.
//   master : cache controller side (drives requests, receives results)
//   slave  : dcache1_tag_bank side
interface dcache1_tag_bank_if #(
  parameter int SET_BITS  = 6,
  parameter int TAG_W     = 30,
  parameter int INV_PORTS = 6,
  parameter int WAY_BITS  = 3
);
  logic                               rd_clkEn;
  logic                               rd_en;
  logic [SET_BITS-1:0]                rd_set;
  logic [TAG_W-1:0]                   rd_tag;
  logic                               rd_invl;
  logic                               wr_en;
  logic                               wr_excl;
  logic [2*WAY_BITS-1:0]              wr_rand;
  logic                               wr_recent_in;
  logic                               flush_req;
  logic [INV_PORTS-1:0]               inv_en;
  logic [INV_PORTS-1:0][SET_BITS-1:0] inv_set;
  logic                               busy;
  logic                               hit;
  logic                               excl;
  logic                               recent_out;
  logic                               wr_hit;
  logic [TAG_W+SET_BITS-1:0]          wb_addr;
  logic                               wb_valid;
  logic                               err;

  modport master (
    output rd_clkEn, rd_en, rd_set, rd_tag, rd_invl, wr_en, wr_excl, wr_rand,
           wr_recent_in, flush_req, inv_en, inv_set,
    input  busy, hit, excl, recent_out, wr_hit, wb_addr, wb_valid, err
  );

  modport slave (
    input  rd_clkEn, rd_en, rd_set, rd_tag, rd_invl, wr_en, wr_excl, wr_rand,
           wr_recent_in, flush_req, inv_en, inv_set,
    output busy, hit, excl, recent_out, wr_hit, wb_addr, wb_valid, err
  );
endinterface

// File: rtl/dcache1_tag_bank_ram.sv
// dcache1_tag_bank_ram: storage of one tag way.
//   entry array : async read at rd_addr, one write port (we/wr_addr/wr_ent)
//   valid array : read at rd_addr, one write port (vwe/v_wdata at wr_addr),
//                 INV_PORTS clear ports (inv_en/inv_set) that beat the write.
// No reset on the arrays; the owner sweeps them after reset.
module dcache1_tag_bank_ram #(
  parameter int SET_BITS  = 6,
  parameter int EW        = 32,
  parameter int INV_PORTS = 6
) (
  input  logic                               clk,
  input  logic [SET_BITS-1:0]                rd_addr,
  output logic [EW-1:0]                      rd_ent,
  output logic                               rd_vld,
  input  logic                               we,
  input  logic [SET_BITS-1:0]                wr_addr,
  input  logic [EW-1:0]                      wr_ent,
  input  logic                               vwe,
  input  logic                               v_wdata,
  input  logic [INV_PORTS-1:0]               inv_en,
  input  logic [INV_PORTS-1:0][SET_BITS-1:0] inv_set
);
  localparam int SETS = 1 << SET_BITS;

  logic [EW-1:0]   ent_q [SETS];
  logic [SETS-1:0] vld_q;
  logic [SETS-1:0] inv_hit;

  always_ff @(posedge clk)
    if (we) ent_q[wr_addr] <= wr_ent;

  assign rd_ent = ent_q[rd_addr];
  assign rd_vld = vld_q[rd_addr];

  // Any number of ports may name the same set; they simply OR together.
  always_comb begin
    inv_hit = '0;
    for (int p = 0; p < INV_PORTS; p++)
      if (inv_en[p]) inv_hit[inv_set[p]] = 1'b1;
  end

  always_ff @(posedge clk)
    for (int s = 0; s < SETS; s++)
      if (inv_hit[s])                               vld_q[s] <= 1'b0;
      else if (vwe && wr_addr == SET_BITS'(s))      vld_q[s] <= v_wdata;

endmodule

// File: rtl/dcache1_tag_bank.sv
// dcache1_tag_bank: one way of the L1 D-cache tag array.
//   clk, rst : clock (posedge) and asynchronous active-high reset
//   bus      : dcache1_tag_bank_if.slave -- lookup (rd_*), fill (wr_*),
//              flush_req, snoop invalidates (inv_*), and results
//              busy/hit/excl/recent_out/wr_hit/wb_addr/wb_valid/err.
// Two-stage lookup: stage 0 registers the request, stage 1 reads the arrays
// at the registered set and resolves hit / victim; updates land at the end
// of stage 1. An INIT/FLUSH sweep zeroes every set, one per cycle.
// Optional feature macro: DCACHE1_TAG_PARITY_EN (stored even parity + err).
module dcache1_tag_bank
  import dc1_tag_pkg::*;
#(
  parameter int SET_BITS  = 6,
  parameter int TAG_W     = 30,
  parameter int INV_PORTS = 6,
  parameter int WAY_BITS  = 3,
  parameter int WAY_INDEX = 0
) (
  input  logic               clk,
  input  logic               rst,
  dcache1_tag_bank_if.slave  bus
);
  localparam int                  EW   = dc1_ent_w(TAG_W);
  localparam logic [SET_BITS-1:0] LAST = '1;
  localparam logic [WAY_BITS-1:0] WAYV = WAY_BITS'(WAY_INDEX);

  dc1_state_e          state;
  logic [SET_BITS-1:0] cnt;
  logic                busy_q;

  logic                s1_en, s1_wr, s1_invl;
  logic [SET_BITS-1:0] s1_set;
  logic [TAG_W-1:0]    s1_tag;

  logic [EW-1:0]       ram_rent, ram_wdata;
  logic                ram_rvld, ram_we, vld_we, vld_wdata;
  logic [SET_BITS-1:0] ram_waddr;

  dc1_tag_entry_t      s1_f;
  logic [TAG_W-1:0]    ent_tag, w_tag;
  logic                w_excl, w_recent;
  logic                live, par_err, hit_c, wr_hit_c;
  logic [WAY_BITS-1:0] way_sel;

  // ---- sweep FSM: busy is registered alongside the state ----
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= INIT;
      cnt    <= '0;
      busy_q <= 1'b1;
    end else begin
      case (state)
        INIT, FLUSH: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state  <= RUN;
            busy_q <= 1'b0;
          end
        end
        RUN:
          if (bus.flush_req) begin
            state  <= FLUSH;
            cnt    <= '0;
            busy_q <= 1'b1;
          end
        default: begin
          state  <= INIT;
          cnt    <= '0;
          busy_q <= 1'b1;
        end
      endcase
    end

  // ---- stage 0 -> stage 1 registers ----
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_en   <= 1'b0;
      s1_set  <= '0;
      s1_tag  <= '0;
      s1_wr   <= 1'b0;
      s1_invl <= 1'b0;
    end else begin
      if (bus.rd_clkEn) begin
        s1_en  <= bus.rd_en;
        s1_set <= bus.rd_set;
        s1_tag <= bus.rd_tag;
      end else begin
        s1_en  <= 1'b0;
      end
      s1_wr   <= bus.wr_en;
      s1_invl <= bus.rd_invl;
    end

  dcache1_tag_bank_ram #(
    .SET_BITS (SET_BITS),
    .EW       (EW),
    .INV_PORTS(INV_PORTS)
  ) u_ram (
    .clk    (clk),
    .rd_addr(s1_set),
    .rd_ent (ram_rent),
    .rd_vld (ram_rvld),
    .we     (ram_we),
    .wr_addr(ram_waddr),
    .wr_ent (ram_wdata),
    .vwe    (vld_we),
    .v_wdata(vld_wdata),
    .inv_en (bus.inv_en & {INV_PORTS{~busy_q}}),
    .inv_set(bus.inv_set)
  );

  // ---- stage 1 decode ----
  assign ent_tag = ram_rent[TAG_W-1:0];

  always_comb begin
    s1_f        = '0;
    s1_f.recent = ram_rent[TAG_W+OFF_RECENT];
    s1_f.excl   = ram_rent[TAG_W+OFF_EXCL];
    s1_f.valid  = ram_rvld;
`ifdef DCACHE1_TAG_PARITY_EN
    s1_f.parity = ram_rent[TAG_W+OFF_PARITY];
`endif
  end

`ifdef DCACHE1_TAG_PARITY_EN
  assign par_err = ^ram_rent;
`else
  assign par_err = 1'b0;
`endif

  assign live     = ~busy_q;
  assign hit_c    = s1_en & live & s1_f.valid & (ent_tag == s1_tag) & ~par_err;
  assign way_sel  = bus.wr_recent_in ? bus.wr_rand[2*WAY_BITS-1:WAY_BITS]
                                     : bus.wr_rand[WAY_BITS-1:0];
  assign wr_hit_c = s1_wr & live & (way_sel == WAYV);

  assign bus.busy       = busy_q;
  assign bus.hit        = hit_c;
  assign bus.err        = s1_en & live & par_err;
  assign bus.excl       = s1_en & live & s1_f.excl & ~par_err;
  assign bus.recent_out = s1_wr & live & (bus.wr_rand[WAY_BITS-1:0] == WAYV) & s1_f.recent;
  assign bus.wr_hit     = wr_hit_c;
  // Driven to 0 when not the victim so the ways can be ORed together.
  assign bus.wb_addr    = wr_hit_c ? {ent_tag, s1_set} : '0;
  assign bus.wb_valid   = wr_hit_c & s1_f.valid;

  // ---- end-of-stage-1 update: sweep > fill > recent/invalidate rewrite ----
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = s1_set;
    vld_we    = 1'b0;
    vld_wdata = 1'b0;
    w_tag     = '0;
    w_excl    = 1'b0;
    w_recent  = 1'b0;
    if (busy_q) begin
      ram_we    = 1'b1;
      ram_waddr = cnt;
      vld_we    = 1'b1;
    end else if (wr_hit_c) begin
      ram_we    = 1'b1;
      vld_we    = 1'b1;
      vld_wdata = 1'b1;
      w_tag     = s1_tag;
      w_excl    = bus.wr_excl;
    end else if (s1_en && !par_err) begin
      // A corrupted entry is left alone so the error stays visible.
      ram_we    = 1'b1;
      vld_we    = 1'b1;
      vld_wdata = s1_f.valid & ~(s1_invl & hit_c);
      w_tag     = ent_tag;
      w_excl    = s1_f.excl;
      w_recent  = hit_c;
    end
  end

`ifdef DCACHE1_TAG_PARITY_EN
  assign ram_wdata = {^{w_excl, w_recent, w_tag}, w_excl, w_recent, w_tag};
`else
  assign ram_wdata = {w_excl, w_recent, w_tag};
`endif

endmodule

// File: tb/tb_dcache1_tag_bank.sv
// tb_dcache1_tag_bank: directed-vector bench for dcache1_tag_bank
// (WAY_INDEX=2). Inputs change 1ns after the rising edge; outputs are
// sampled 3ns after the edge.
module tb_dcache1_tag_bank;
  localparam int SB = 6;
  localparam int TW = 30;
  localparam int IP = 6;
  localparam int WB = 3;
  localparam int WI = 2;
  localparam logic [WB-1:0] WIV = WB'(WI);

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  dcache1_tag_bank_if #(.SET_BITS(SB), .TAG_W(TW), .INV_PORTS(IP), .WAY_BITS(WB)) bus ();

  dcache1_tag_bank #(
    .SET_BITS(SB), .TAG_W(TW), .INV_PORTS(IP), .WAY_BITS(WB), .WAY_INDEX(WI)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rd_clkEn     = 1'b1;
    bus.rd_en        = 1'b0;
    bus.rd_invl      = 1'b0;
    bus.wr_en        = 1'b0;
    bus.wr_excl      = 1'b0;
    bus.wr_rand      = '0;
    bus.wr_recent_in = 1'b0;
    bus.flush_req    = 1'b0;
    bus.inv_en       = '0;
  endtask

  task automatic drive_rd(input int set, input logic [TW-1:0] tag);
    bus.rd_en  = 1'b1;
    bus.rd_set = SB'(set);
    bus.rd_tag = tag;
  endtask

  // stage 0 lookup, then sample stage-1 results
  task automatic look(input int set, input logic [TW-1:0] tag, input logic invl,
                      output logic h, output logic e);
    drive_rd(set, tag);
    bus.rd_invl = invl;
    cyc();
    idle();
    #2;
    h = bus.hit;
    e = bus.excl;
  endtask

  // fill `set` with `tag` into this way via the primary victim field
  task automatic fill(input int set, input logic [TW-1:0] tag, input logic x);
    drive_rd(set, tag);
    bus.wr_en = 1'b1;
    cyc();
    idle();
    bus.wr_rand = {3'd0, WIV};
    bus.wr_excl = x;
    cyc();
    idle();
  endtask

  // count samples with busy high; optionally pulse flush_req at sample pulse_at
  task automatic busy_len(input int pulse_at, output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 300) begin
      if (n == pulse_at) bus.flush_req = 1'b1;
      n++;
      cyc();
      bus.flush_req = 1'b0;
    end
  endtask

  task automatic scan(input logic [TW-1:0] base, output int hits);
    hits = 0;
    for (int s = 0; s < 64; s++) begin
      drive_rd(s, base + TW'(s));
      cyc();
      #2;
      if (bus.hit === 1'b1) hits++;
    end
    idle();
  endtask

  task automatic fill_all(input logic [TW-1:0] base);
    bus.wr_rand = {3'd0, WIV};
    for (int s = 0; s < 64; s++) begin
      drive_rd(s, base + TW'(s));
      bus.wr_en = 1'b1;
      cyc();
    end
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    cyc();
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int   n, hits;
    logic h, e;
    idle();
    bus.rd_set  = '0;
    bus.rd_tag  = '0;
    bus.inv_set = '0;
    rst = 1'b1;
    #1;
    chk("rst_busy",   64'(bus.busy),       64'd1);
    chk("rst_hit",    64'(bus.hit),        64'd0);
    chk("rst_wr_hit", 64'(bus.wr_hit),     64'd0);
    chk("rst_wb",     64'(bus.wb_addr),    64'd0);
    chk("rst_wbv",    64'(bus.wb_valid),   64'd0);
    chk("rst_err",    64'(bus.err),        64'd0);
    chk("rst_excl",   64'(bus.excl),       64'd0);
    chk("rst_recent", 64'(bus.recent_out), 64'd0);
    #1 rst = 1'b0;

    busy_len(-1, n);
    chk("init_len", 64'(n), 64'd64);
    scan('0, hits);
    chk("init_miss", 64'(hits), 64'd0);

    // fill set 5 with write-first lookup in the same cycle
    drive_rd(5, 30'h1234);
    bus.wr_en = 1'b1;
    cyc();
    idle();
    bus.wr_rand = {3'd0, WIV};
    bus.wr_excl = 1'b1;
    drive_rd(5, 30'h1234);
    #2;
    chk("fill_wr_hit", 64'(bus.wr_hit),   64'd1);
    chk("fill_wbv",    64'(bus.wb_valid), 64'd0);
    chk("fill_wb",     64'(bus.wb_addr),  64'd5);
    cyc();
    idle();
    #2;
    chk("fill_hit",  64'(bus.hit),  64'd1);
    chk("fill_excl", 64'(bus.excl), 64'd1);

    // recent bit set by the hit; alternate field selects another way
    drive_rd(5, 30'h1234);
    bus.wr_en = 1'b1;
    cyc();
    idle();
    bus.wr_recent_in = 1'b1;
    bus.wr_rand = {3'd1, WIV};
    #2;
    chk("rec_out",    64'(bus.recent_out), 64'd1);
    chk("rec_wr_hit", 64'(bus.wr_hit),     64'd0);
    chk("rec_hit",    64'(bus.hit),        64'd1);

    // alternate victim field names this way; old line written back
    drive_rd(5, 30'hABC);
    bus.wr_en = 1'b1;
    cyc();
    idle();
    bus.wr_recent_in = 1'b1;
    bus.wr_rand = {WIV, 3'd7};
    drive_rd(5, 30'hABC);
    #2;
    chk("vic_wr_hit", 64'(bus.wr_hit),   64'd1);
    chk("vic_wb",     64'(bus.wb_addr),  64'({30'h1234, 6'd5}));
    chk("vic_wbv",    64'(bus.wb_valid), 64'd1);
    chk("vic_hit",    64'(bus.hit),      64'd0);
    cyc();
    idle();
    #2;
    chk("vic_look_hit",  64'(bus.hit),  64'd1);
    chk("vic_look_excl", 64'(bus.excl), 64'd0);

    // snoop invalidate beats a simultaneous fill of the same set
    drive_rd(5, 30'h777);
    bus.wr_en = 1'b1;
    cyc();
    idle();
    bus.wr_rand    = {3'd0, WIV};
    bus.inv_en[3]  = 1'b1;
    bus.inv_set[3] = 6'd5;
    drive_rd(5, 30'h777);
    #2;
    chk("snp_wr_hit", 64'(bus.wr_hit), 64'd1);
    cyc();
    idle();
    #2;
    chk("snp_hit", 64'(bus.hit), 64'd0);

    // invalidate of the set in stage 1 only affects later lookups
    fill(9, 30'h99, 1'b0);
    drive_rd(9, 30'h99);
    cyc();
    idle();
    bus.inv_en[0]  = 1'b1;
    bus.inv_set[0] = 6'd9;
    drive_rd(9, 30'h99);
    #2;
    chk("inv_same", 64'(bus.hit), 64'd1);
    cyc();
    idle();
    #2;
    chk("inv_after", 64'(bus.hit), 64'd0);

    // rd_invl clears valid on hit
    fill(12, 30'h55, 1'b0);
    look(12, 30'h55, 1'b1, h, e);
    chk("rdinvl_hit", 64'(h), 64'd1);
    look(12, 30'h55, 1'b0, h, e);
    chk("rdinvl_after", 64'(h), 64'd0);

    // rd_clkEn low drops the lookup; two ports invalidating one set
    fill(20, 30'h2020, 1'b1);
    bus.rd_clkEn = 1'b0;
    look(20, 30'h2020, 1'b0, h, e);
    chk("clken_off", 64'(h), 64'd0);
    look(20, 30'h2020, 1'b0, h, e);
    chk("clken_on", 64'(h), 64'd1);
    bus.inv_en     = 6'b010010;
    bus.inv_set[1] = 6'd20;
    bus.inv_set[4] = 6'd20;
    cyc();
    idle();
    look(20, 30'h2020, 1'b0, h, e);
    chk("multi_inv", 64'(h), 64'd0);

    // flush after filling every set; second flush_req mid-sweep ignored
    fill_all(30'h100);
    look(0, 30'h100, 1'b0, h, e);
    chk("all_hit0", 64'(h), 64'd1);
    look(63, 30'h13F, 1'b0, h, e);
    chk("all_hit63", 64'(h), 64'd1);
    bus.flush_req = 1'b1;
    cyc();
    bus.flush_req = 1'b0;
    busy_len(20, n);
    chk("flush_len", 64'(n), 64'd64);
    scan(30'h100, hits);
    chk("flush_miss", 64'(hits), 64'd0);

    // async reset while a hit is showing in stage 1
    fill(30, 30'h3030, 1'b0);
    drive_rd(30, 30'h3030);
    cyc();
    idle();
    #2;
    chk("pre_rst_hit", 64'(bus.hit), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_run_hit",  64'(bus.hit),  64'd0);
    chk("rst_run_busy", 64'(bus.busy), 64'd1);
    #1 rst = 1'b0;
    busy_len(-1, n);
    chk("rst_run_len", 64'(n), 64'd64);

    // async reset mid-FLUSH restarts the sweep from set 0
    bus.flush_req = 1'b1;
    cyc();
    bus.flush_req = 1'b0;
    repeat (10) cyc();
    #2 rst = 1'b1;
    #1;
    chk("rstfl_busy", 64'(bus.busy),   64'd1);
    chk("rstfl_whit", 64'(bus.wr_hit), 64'd0);
    chk("rstfl_wb",   64'(bus.wb_addr), 64'd0);
    #1 rst = 1'b0;
    busy_len(-1, n);
    chk("rstfl_len", 64'(n), 64'd64);

`ifdef DCACHE1_TAG_PARITY_EN
    fill(7, 30'h3, 1'b1);
    u_dut.u_ram.ent_q[7][TW+1] = ~u_dut.u_ram.ent_q[7][TW+1];
    look(7, 30'h3, 1'b0, h, e);
    chk("par_err",  64'(bus.err), 64'd1);
    chk("par_hit",  64'(h),       64'd0);
    chk("par_excl", 64'(e),       64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
